// File: rtl/exec_unit_pkg.sv
// Shared types for the decode stage and the exec unit it feeds:
// opcode encodings, operand selects and the decoded-instruction record.
package exec_unit_pkg;

  typedef enum logic [6:0] {
    OP     = 7'b0110011,
    OP_IMM = 7'b0010011,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111
  } rv_opcode_t;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [3:0] EXEC_ADD = 4'b0000;

  typedef enum logic {
    OP1_REG = 1'b0,
    OP1_PC  = 1'b1
  } op1_sel_t;

  typedef enum logic {
    OP2_REG = 1'b0,
    OP2_IMM = 1'b1
  } op2_sel_t;

  typedef struct packed {
    op1_sel_t   operand1_sel;
    op2_sel_t   operand2_sel;
    logic [3:0] exec_op;
  } exec_unit_params_t;

  typedef struct packed {
    exec_unit_params_t params;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic [31:0]       pc;
    logic              rd_we;
    logic              illegal;
  } decoded_instr_t;

endpackage

// File: rtl/alu_instr_decode_comb.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC; anything
// else becomes an illegal entry with a harmless ADD and no write-back.
module alu_instr_decode_comb
  import exec_unit_pkg::*;
(
  input  logic [31:0]    instr_i,
  input  logic [31:0]    pc_i,
  output decoded_instr_t dec_o
);

  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       legal;

  assign funct7 = instr_i[31:25];
  assign funct3 = instr_i[14:12];

  // NOTE: every output gets a default before the case, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    dec_o       = '0;
    dec_o.rs1   = instr_i[19:15];
    dec_o.rs2   = instr_i[24:20];
    dec_o.rd    = instr_i[11:7];
    dec_o.pc    = pc_i;
    dec_o.rd_we = 1'b1;
    legal       = 1'b0;

    case (instr_i[6:0])
      OP: begin
        dec_o.params.exec_op = {funct7[5], funct3};
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OP_IMM: begin
        dec_o.params.operand2_sel = OP2_IMM;
        case (funct3)
          3'b001: begin
            dec_o.params.exec_op = {1'b0, funct3};
            dec_o.imm            = {27'b0, instr_i[24:20]};
            legal                = (funct7 == F7_BASE);
          end
          3'b101: begin
            dec_o.params.exec_op = {instr_i[30], funct3};
            dec_o.imm            = {27'b0, instr_i[24:20]};
            legal                = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: begin
            dec_o.params.exec_op = {1'b0, funct3};
            dec_o.imm            = {{20{instr_i[31]}}, instr_i[31:20]};
            legal                = 1'b1;
          end
        endcase
      end
      LUI: begin
        dec_o.rs1                 = 5'd0;
        dec_o.params.operand2_sel = OP2_IMM;
        dec_o.params.exec_op      = EXEC_ADD;
        dec_o.imm                 = {instr_i[31:12], 12'b0};
        legal                     = 1'b1;
      end
      AUIPC: begin
        dec_o.params.operand1_sel = OP1_PC;
        dec_o.params.operand2_sel = OP2_IMM;
        dec_o.params.exec_op      = EXEC_ADD;
        dec_o.imm                 = {instr_i[31:12], 12'b0};
        legal                     = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Opcodes with instr[1:0] != 2'b11 never match above, so they land here too.
    if (!legal) begin
      dec_o.params.operand1_sel = OP1_REG;
      dec_o.params.operand2_sel = OP2_REG;
      dec_o.params.exec_op      = EXEC_ADD;
      dec_o.imm                 = '0;
      dec_o.rd_we               = 1'b0;
      dec_o.illegal             = 1'b1;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode pipeline stage: valid/ready in, registered valid/ready out, with an
// optional skid entry so in_ready comes straight from a flop.
module alu_decode_stage
  import exec_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int REGISTERED_READY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_params,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_rd_we,
  output logic            out_illegal
);

  decoded_instr_t dec;
  decoded_instr_t out_q, out_d;
  decoded_instr_t skid_q, skid_d;
  logic           out_valid_q, out_valid_d;
  logic           skid_valid_q, skid_valid_d;
  logic           accept;
  logic           drain;

  alu_instr_decode_comb u_decode (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .dec_o   (dec)
  );

  assign in_ready = (REGISTERED_READY != 0) ? ~skid_valid_q
                                            : (out_ready | ~out_valid_q);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid_q & out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain) begin
      // The skid entry is older than anything on the input, so it goes first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept && (REGISTERED_READY != 0)) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
    end
  end

  // NOTE: skid payload has no reset; skid_valid_q alone says whether it means anything.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign out_valid   = out_valid_q;
  assign out_params  = out_q.params;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_pc      = out_q.pc;
  assign out_rd_we   = out_q.rd_we;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: hand-derived expectations are
// queued on each accepted input and compared when the stage emits them.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [5:0]  params;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        rd_we;
    logic        illegal;
    logic        rs1_c;
    logic        rs2_c;
    logic        rd_c;
    logic        imm_c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_params;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic        out_rd_we;
  logic        out_illegal;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t cur_exp;
  exp_t exp_q[$];

  alu_decode_stage #(.XLEN(32), .REGISTERED_READY(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_params  (out_params),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .out_pc      (out_pc),
    .out_rd_we   (out_rd_we),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [5:0] params, input logic [4:0] rs1, rs2, rd,
                              input logic [31:0] imm, pc, input logic we, ill,
                              input logic [3:0] care);
    exp_t e;
    e.params  = params;
    e.rs1     = rs1;
    e.rs2     = rs2;
    e.rd      = rd;
    e.imm     = imm;
    e.pc      = pc;
    e.rd_we   = we;
    e.illegal = ill;
    {e.rs1_c, e.rs2_c, e.rd_c, e.imm_c} = care;
    return e;
  endfunction

  // Scoreboard: inputs change just after posedge, so at negedge the
  // handshake signals already show what the next edge will transfer.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output: got rd=%0d params=%h pc=%h, want no output",
                   out_rd, out_params, out_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ((out_params !== e.params) || (out_pc !== e.pc) ||
              (out_rd_we !== e.rd_we) || (out_illegal !== e.illegal) ||
              (e.rs1_c && (out_rs1 !== e.rs1)) || (e.rs2_c && (out_rs2 !== e.rs2)) ||
              (e.rd_c && (out_rd !== e.rd)) || (e.imm_c && (out_imm !== e.imm))) begin
            miscompares++;
            $display("FAIL out_entry: got params=%h rs1=%0d rs2=%0d rd=%0d imm=%h pc=%h we=%b ill=%b, want params=%h rs1=%0d rs2=%0d rd=%0d imm=%h pc=%h we=%b ill=%b",
                     out_params, out_rs1, out_rs2, out_rd, out_imm, out_pc, out_rd_we, out_illegal,
                     e.params, e.rs1, e.rs2, e.rd, e.imm, e.pc, e.rd_we, e.illegal);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
    int n;
    in_instr = instr;
    in_pc    = pc;
    cur_exp  = e;
    in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stayed %b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries still pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b, want 0", out_valid);
    end
    vectors++;
    if ({out_params, out_rs1, out_rs2, out_rd, out_imm, out_pc, out_rd_we, out_illegal} !== '0) begin
      miscompares++;
      $display("FAIL reset_out_data: got params=%h rd=%0d imm=%h pc=%h we=%b ill=%b, want all 0",
               out_params, out_rd, out_imm, out_pc, out_rd_we, out_illegal);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_latency();
    out_ready = 1'b1;
    send(32'h002081B3, 32'h0000_0000, mk(6'h00, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 1'b1, 1'b0, 4'b1110));
    @(negedge clk);
    vectors++;
    if ((out_valid !== 1'b1) || (out_rd !== 5'd3)) begin
      miscompares++;
      $display("FAIL add_latency: got valid=%b rd=%0d, want valid=1 rd=3", out_valid, out_rd);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_decode_mix();
    out_ready = 1'b1;
    send(32'h407302B3, 32'h0000_0010, mk(6'h08, 5'd6, 5'd7, 5'd5, 32'h0, 32'h10, 1'b1, 1'b0, 4'b1110));
    send(32'h4030D093, 32'h0000_0014, mk(6'h1D, 5'd1, 5'd0, 5'd1, 32'h3, 32'h14, 1'b1, 1'b0, 4'b1011));
    send(32'hFFF00093, 32'h0000_0018, mk(6'h10, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 32'h18, 1'b1, 1'b0, 4'b1011));
    send(32'h12345117, 32'h0000_0100, mk(6'h30, 5'd0, 5'd0, 5'd2, 32'h1234_5000, 32'h100, 1'b1, 1'b0, 4'b0011));
    send(32'h123450B7, 32'h0000_0104, mk(6'h10, 5'd0, 5'd0, 5'd1, 32'h1234_5000, 32'h104, 1'b1, 1'b0, 4'b1011));
    send(32'h00509093, 32'h0000_0108, mk(6'h11, 5'd1, 5'd0, 5'd1, 32'h5, 32'h108, 1'b1, 1'b0, 4'b1011));
    send(32'h00208033, 32'h0000_010C, mk(6'h00, 5'd1, 5'd2, 5'd0, 32'h0, 32'h10C, 1'b1, 1'b0, 4'b1110));
    wait_drain();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send(32'h002081B2, 32'h0000_0200, mk(6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h200, 1'b0, 1'b1, 4'b0001));
    send(32'h40109093, 32'h0000_0204, mk(6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h204, 1'b0, 1'b1, 4'b0001));
    send(32'h40209033, 32'h0000_0208, mk(6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h208, 1'b0, 1'b1, 4'b0001));
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3;
    in_pc     = 32'h300;
    cur_exp   = mk(6'h00, 5'd1, 5'd2, 5'd3, 32'h0, 32'h300, 1'b1, 1'b0, 4'b1110);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_first_ready: got %b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_instr = 32'h407302B3;
    in_pc    = 32'h304;
    cur_exp  = mk(6'h08, 5'd6, 5'd7, 5'd5, 32'h0, 32'h304, 1'b1, 1'b0, 4'b1110);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_second_ready: got %b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_instr = 32'hFFF00093;
    in_pc    = 32'h308;
    cur_exp  = mk(6'h10, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 32'h308, 1'b1, 1'b0, 4'b1011);
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ((in_ready !== 1'b0) || (out_valid !== 1'b1) || (out_rd !== 5'd3) ||
          (out_pc !== 32'h300) || (out_params !== 6'h00)) begin
        miscompares++;
        $display("FAIL bp_stall: got in_ready=%b valid=%b rd=%0d pc=%h params=%h, want 0 1 3 00000300 00",
                 in_ready, out_valid, out_rd, out_pc, out_params);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release_edge: in_ready got %b, want 0", in_ready);
    end
    @(posedge clk);
    #1;
    n = 0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready_rise: got %b, want 1", in_ready);
    end
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h002081B3, 32'h400, mk(6'h00, 5'd1, 5'd2, 5'd3, 32'h0, 32'h400, 1'b1, 1'b0, 4'b1110));
    send(32'h407302B3, 32'h404, mk(6'h08, 5'd6, 5'd7, 5'd5, 32'h0, 32'h404, 1'b1, 1'b0, 4'b1110));
    in_valid = 1'b1;
    in_instr = 32'h12345117;
    in_pc    = 32'h408;
    cur_exp  = mk(6'h30, 5'd0, 5'd0, 5'd2, 32'h1234_5000, 32'h408, 1'b1, 1'b0, 4'b0011);
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ((out_valid !== 1'b0) || (in_ready !== 1'b1)) begin
      miscompares++;
      $display("FAIL flush_state: got valid=%b in_ready=%b, want valid=0 in_ready=1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(32'h00509093, 32'h40C, mk(6'h11, 5'd1, 5'd0, 5'd1, 32'h5, 32'h40C, 1'b1, 1'b0, 4'b1011));
    wait_drain();
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    send(32'h002081B3, 32'h500, mk(6'h00, 5'd1, 5'd2, 5'd3, 32'h0, 32'h500, 1'b1, 1'b0, 4'b1110));
    send(32'h407302B3, 32'h504, mk(6'h08, 5'd6, 5'd7, 5'd5, 32'h0, 32'h504, 1'b1, 1'b0, 4'b1110));
    test_reset();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    cur_exp   = '0;
    test_reset();
    test_add_latency();
    test_decode_mix();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
